// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 SPI sink: command codes, the queued item
// type and the shift FSM state encoding.
package st7735_pkg;

  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] RASET   = 8'h2B;
  localparam logic [7:0] RAMWR   = 8'h2C;
  localparam logic [7:0] MADCTL  = 8'h36;
  localparam logic [7:0] COLMOD  = 8'h3A;

  typedef struct packed {
    logic       dc;
    logic [7:0] b;
  } st7735_item_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } sink_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of generic items with full/empty flags. The head is
// presented only while non-empty (zero otherwise); a push into a full FIFO is
// accepted only when a pop happens on the same cycle.
module sync_fifo
  import st7735_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = st7735_item_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T            r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_pop_ok;
  logic        w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data = o_empty ? T'('0) : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/st7735_spi_sink.sv
// Write-only SPI mode-0 receiver modelling the ST7735 side of the display link:
// oversampled inputs, byte reassembly, DC-tagged FIFO and command context.
module st7735_spi_sink
  import st7735_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PIX_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk,
  input  logic             i_copi,
  input  logic             i_tft_cs,
  input  logic             i_tft_dc,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic [7:0]       o_rx_byte,
  output logic             o_rx_dc,
  output logic [7:0]       o_last_cmd,
  output logic [7:0]       o_param_cnt,
  output logic [PIX_W-1:0] o_pixel_cnt,
  output logic             o_partial_err,
  output logic             o_overflow
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic                   r_sclk_prev;
  logic                   r_sclk_rise;

  logic w_sclk_s;
  logic w_copi_s;
  logic w_cs_s;
  logic w_dc_s;

  sink_state_t  r_state;
  sink_state_t  w_state_next;
  logic [2:0]   r_bit_cnt;
  logic [2:0]   w_bit_cnt_next;
  logic [7:0]   r_shreg;
  logic [7:0]   w_shreg_next;
  logic         w_push;
  logic         w_partial;
  st7735_item_t w_push_item;

  logic [7:0]       r_last_cmd;
  logic [7:0]       r_param_cnt;
  logic [PIX_W-1:0] r_pixel_cnt;
  logic             r_phase;
  logic             r_partial_err;
  logic             r_overflow;

  st7735_item_t w_head;
  logic         w_full;
  logic         w_empty;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s = r_copi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];

  // Chip select resets high so a reset never looks like a transfer start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_cs_sync   <= '1;
      r_dc_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_sclk_rise <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_copi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_tft_cs};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], i_tft_dc};
      r_sclk_prev <= w_sclk_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_prev;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_partial_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_shreg       <= w_shreg_next;
      r_partial_err <= w_partial;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shreg_next   = r_shreg;
    w_push         = 1'b0;
    w_partial      = 1'b0;
    w_push_item    = '0;
    w_push_item.dc = w_dc_s;
    w_push_item.b  = {r_shreg[6:0], w_copi_s};
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_s) begin
          w_state_next   = ST_SHIFT;
          w_bit_cnt_next = '0;
        end
      end
      ST_SHIFT: begin
        // Deselect takes priority: a rise coinciding with cs high is ignored.
        if (w_cs_s) begin
          w_state_next   = ST_IDLE;
          w_partial      = (r_bit_cnt != 3'd0);
          w_bit_cnt_next = '0;
        end else if (r_sclk_rise) begin
          w_shreg_next   = {r_shreg[6:0], w_copi_s};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          w_push         = (r_bit_cnt == 3'd7);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Context follows every received byte, even one the FIFO has to drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_cmd  <= '0;
      r_param_cnt <= '0;
      r_pixel_cnt <= '0;
      r_phase     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        if (!w_push_item.dc) begin
          r_last_cmd  <= w_push_item.b;
          r_param_cnt <= '0;
          r_phase     <= 1'b0;
          if (w_push_item.b == RAMWR) r_pixel_cnt <= '0;
        end else begin
          r_param_cnt <= sat_inc8(r_param_cnt);
          if (r_last_cmd == RAMWR) begin
            r_phase <= ~r_phase;
            if (r_phase) r_pixel_cnt <= r_pixel_cnt + PIX_W'(1);
          end
        end
      end
      if (w_push && w_full && !i_rx_ready) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (st7735_item_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_item),
    .i_pop   (i_rx_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rx_valid    = ~w_empty;
  assign o_rx_byte     = w_head.b;
  assign o_rx_dc       = w_head.dc;
  assign o_last_cmd    = r_last_cmd;
  assign o_param_cnt   = r_param_cnt;
  assign o_pixel_cnt   = r_pixel_cnt;
  assign o_partial_err = r_partial_err;
  assign o_overflow    = r_overflow;

endmodule
